aes_bist_engine: RTL and testbench

Parametrised, self-checking logic-BIST engine for the AES-128 8-bit-datapath IP. It generalises the current fixed-width LFSR/MISR BIST with configurable datapath, LFSR and MISR widths and a programmable pattern count, seed and drain length. It adds on-chip comparison against a golden signature and abort support. It sits between the AHB register block, which owns `start`/`abort` and the config, and the AES core's key/data/valid muxes.

---
 rtl/aes_bist_pkg.sv | 24 ++
 rtl/bist_shift_reg.sv | 41 ++++
 rtl/aes_bist_engine.sv | 171 +++++++++++++++++
 tb/tb_aes_bist_engine.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_bist_pkg.sv
// Shared types and constants for the AES logic-BIST engine.
package aes_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDrst,
    StRun,
    StDrain,
    StCmp,
    StDone
  } bist_state_e;

  // x^16+x^14+x^13+x^11+1 and x^32+x^22+x^2+x+1
  localparam logic [15:0] BIST_TAPS_16 = 16'hB400;
  localparam logic [31:0] BIST_TAPS_32 = 32'h8020_0003;

  function automatic bit widths_ok(input int unsigned dw, input int unsigned lfsr_w,
                                   input int unsigned misr_w, input int unsigned rst_cycles,
                                   input int unsigned cnt_w);
    return (dw >= 1) && (dw <= lfsr_w) && (misr_w >= dw) && (rst_cycles >= 1) &&
           (lfsr_w >= 2) && (misr_w >= 2) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/bist_shift_reg.sv
// Fibonacci-style shift register usable as pattern LFSR or as signature MISR.
module bist_shift_reg #(
  parameter int unsigned   W         = 16,
  parameter logic [W-1:0]  TAPS      = W'(16'hB400),
  parameter bit            MISR_MODE = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] q_o
);

  // LFSR resets to 1 so it never sits in the all-zero lock-up state.
  localparam logic [W-1:0] RstVal = MISR_MODE ? '0 : W'(1);

  logic [W-1:0] q_q, q_d, shifted;

  always_comb begin
    shifted = {q_q[W-2:0], ^(q_q & TAPS)};
    q_d     = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (en_i) begin
      q_d = MISR_MODE ? (shifted ^ din_i) : shifted;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= RstVal;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/aes_bist_engine.sv
// Logic-BIST sequencer for the AES byte-path core: reset pulse, LFSR patterns,
// drain, MISR signature and on-chip golden compare.
module aes_bist_engine
  import aes_bist_pkg::*;
#(
  parameter int unsigned        DW         = 8,
  parameter int unsigned        LFSR_W     = 16,
  parameter int unsigned        MISR_W     = 16,
  parameter logic [LFSR_W-1:0]  LFSR_TAPS  = LFSR_W'(BIST_TAPS_16),
  parameter logic [MISR_W-1:0]  MISR_TAPS  = MISR_W'(BIST_TAPS_16),
  parameter int unsigned        CNT_W      = 16,
  parameter int unsigned        RST_CYCLES = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic              abort,
  input  logic [LFSR_W-1:0] seed,
  input  logic [CNT_W-1:0]  num_patterns,
  input  logic [7:0]        drain_len,
  input  logic [MISR_W-1:0] golden,
  input  logic [DW-1:0]     dut_dout,
  input  logic              dut_valid,
  output logic              is_bist,
  output logic              dut_rst,
  output logic [DW-1:0]     key_out,
  output logic [DW-1:0]     data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  if (!widths_ok(DW, LFSR_W, MISR_W, RST_CYCLES, CNT_W)) begin : gen_param_err
    $error("aes_bist_engine: illegal parameter combination");
  end

  bist_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  npat_q, npat_d;
  logic [7:0]        dlen_q, dlen_d;
  logic              pass_q, pass_d;
  logic              start_ok;
  logic              lfsr_en, misr_en;
  logic [LFSR_W-1:0] lfsr, lfsr_seed;
  logic [MISR_W-1:0] misr;

  assign start_ok  = start && !abort && ((state_q == StIdle) || (state_q == StDone));
  assign lfsr_seed = (seed == '0) ? LFSR_W'(1) : seed;
  // Abort freezes both registers on the aborting edge.
  assign lfsr_en   = (state_q == StRun) && !abort;
  assign misr_en   = ((state_q == StRun) || (state_q == StDrain)) && dut_valid && !abort;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    npat_d  = npat_q;
    dlen_d  = dlen_q;
    pass_d  = pass_q;
    if (abort) begin
      state_d = StIdle;
      pass_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d = StDrst;
            cnt_d   = CNT_W'(RST_CYCLES - 1);
            npat_d  = num_patterns;
            dlen_d  = drain_len;
            pass_d  = 1'b0;
          end
        end
        StDrst: begin
          if (cnt_q == '0) begin
            if (npat_q != '0) begin
              state_d = StRun;
              cnt_d   = npat_q - CNT_W'(1);
            end else if (dlen_q != '0) begin
              state_d = StDrain;
              cnt_d   = CNT_W'(dlen_q) - CNT_W'(1);
            end else begin
              state_d = StCmp;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StRun: begin
          if (cnt_q == '0) begin
            if (dlen_q != '0) begin
              state_d = StDrain;
              cnt_d   = CNT_W'(dlen_q) - CNT_W'(1);
            end else begin
              state_d = StCmp;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StDrain: begin
          if (cnt_q == '0) begin
            state_d = StCmp;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StCmp: begin
          pass_d  = (misr == golden);
          state_d = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      npat_q  <= '0;
      dlen_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      npat_q  <= npat_d;
      dlen_q  <= dlen_d;
      pass_q  <= pass_d;
    end
  end

  bist_shift_reg #(
    .W         (LFSR_W),
    .TAPS      (LFSR_TAPS),
    .MISR_MODE (1'b0)
  ) u_lfsr (
    .clk_i      (HCLK),
    .rst_ni     (HRESETn),
    .load_i     (start_ok),
    .load_val_i (lfsr_seed),
    .en_i       (lfsr_en),
    .din_i      ('0),
    .q_o        (lfsr)
  );

  bist_shift_reg #(
    .W         (MISR_W),
    .TAPS      (MISR_TAPS),
    .MISR_MODE (1'b1)
  ) u_misr (
    .clk_i      (HCLK),
    .rst_ni     (HRESETn),
    .load_i     (start_ok),
    .load_val_i ('0),
    .en_i       (misr_en),
    .din_i      (MISR_W'(dut_dout)),
    .q_o        (misr)
  );

  assign busy      = (state_q == StDrst) || (state_q == StRun) ||
                     (state_q == StDrain) || (state_q == StCmp);
  assign is_bist   = busy;
  assign dut_rst   = (state_q == StDrst);
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign signature = misr;
  assign key_out   = lfsr[DW-1:0];
  assign data_out  = lfsr[LFSR_W-1 -: DW];

endmodule

// File: tb/tb_aes_bist_engine.sv
// Directed bench for aes_bist_engine with hand-computed expectations.
module tb_aes_bist_engine;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        start, abort;
  logic [15:0] seed;
  logic [15:0] num_patterns;
  logic [7:0]  drain_len;
  logic [15:0] golden;
  logic [7:0]  dut_dout;
  logic        dut_valid;
  logic        is_bist, dut_rst, busy, done, pass;
  logic [7:0]  key_out, data_out;
  logic [15:0] signature;

  int vectors = 0;
  int miscompares = 0;
  int bcnt;
  logic [7:0] keys [64];
  logic       rsts [64];

  aes_bist_engine dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .start        (start),
    .abort        (abort),
    .seed         (seed),
    .num_patterns (num_patterns),
    .drain_len    (drain_len),
    .golden       (golden),
    .dut_dout     (dut_dout),
    .dut_valid    (dut_valid),
    .is_bist      (is_bist),
    .dut_rst      (dut_rst),
    .key_out      (key_out),
    .data_out     (data_out),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Pulses start, then records key_out/dut_rst per busy cycle until busy drops.
  task automatic run_op(input logic [15:0] s, input logic [15:0] n, input logic [7:0] d,
                        input string tag, output int cycles);
    seed = s; num_patterns = n; drain_len = d; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_done_clr"}, done, 1'b0);
    check({tag, "_pass_clr"}, pass, 1'b0);
    cycles = 0;
    while (busy && cycles < 200) begin
      if (cycles < 64) begin
        keys[cycles] = key_out;
        rsts[cycles] = dut_rst;
      end
      cycles++;
      tick();
    end
  endtask

  initial begin
    HRESETn = 1'b0; start = 1'b0; abort = 1'b0; seed = '0; num_patterns = '0;
    drain_len = '0; golden = '0; dut_dout = '0; dut_valid = 1'b0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_is_bist", is_bist, 1'b0);
    check("rst_dut_rst", dut_rst, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_sig", signature, 16'h0000);
    check("rst_key", key_out, 8'h01);
    check("rst_data", data_out, 8'h00);
    #8 HRESETn = 1'b1;
    tick();

    // seed 1, N=3, D=0, no valid data
    golden = 16'h0000;
    run_op(16'h0001, 16'd3, 8'd0, "t1", bcnt);
    check("t1_busy_cycles", bcnt, 8);
    check("t1_drst_first", rsts[0], 1'b1);
    check("t1_drst_last", rsts[3], 1'b1);
    check("t1_run_rst", rsts[4], 1'b0);
    check("t1_key0", keys[4], 8'h01);
    check("t1_key1", keys[5], 8'h02);
    check("t1_key2", keys[6], 8'h04);
    check("t1_sig", signature, 16'h0000);
    check("t1_done", done, 1'b1);
    check("t1_pass", pass, 1'b1);
    check("t1_is_bist", is_bist, 1'b0);

    // zero seed behaves like seed 1
    run_op(16'h0000, 16'd3, 8'd0, "t2", bcnt);
    check("t2_busy_cycles", bcnt, 8);
    check("t2_key0", keys[4], 8'h01);
    check("t2_key1", keys[5], 8'h02);
    check("t2_key2", keys[6], 8'h04);
    check("t2_pass", pass, 1'b1);
    check("t2_done", done, 1'b1);

    // N=4, D=2, constant A5: six MISR updates give 18A0
    dut_valid = 1'b1; dut_dout = 8'hA5; golden = 16'h18A0;
    run_op(16'hACE1, 16'd4, 8'd2, "t3", bcnt);
    check("t3_busy_cycles", bcnt, 11);
    check("t3_key0", keys[4], 8'hE1);
    check("t3_sig", signature, 16'h18A0);
    check("t3_pass", pass, 1'b1);
    check("t3_done", done, 1'b1);

    golden = 16'h18A1;
    run_op(16'hACE1, 16'd4, 8'd2, "t3b", bcnt);
    check("t3b_sig", signature, 16'h18A0);
    check("t3b_pass", pass, 1'b0);
    check("t3b_done", done, 1'b1);

    // abort on the 2nd RUN cycle
    seed = 16'h1234; num_patterns = 16'd5; drain_len = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("t4_key_run1", key_out, 8'h34);
    check("t4_data_run1", data_out, 8'h12);
    tick();
    check("t4_key_run2", key_out, 8'h69);
    check("t4_data_run2", data_out, 8'h24);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_busy", busy, 1'b0);
    check("t4_abort_done", done, 1'b0);
    check("t4_abort_dut_rst", dut_rst, 1'b0);
    check("t4_abort_sig", signature, 16'h00A5);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("t4_abort_prio", busy, 1'b0);
    dut_valid = 1'b0; golden = 16'h0000; start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_restart_busy", busy, 1'b1);
    check("t4_restart_sig", signature, 16'h0000);
    repeat (4) tick();
    check("t4_restart_key", key_out, 8'h34);
    check("t4_restart_data", data_out, 8'h12);
    bcnt = 0;
    while (busy && bcnt < 200) begin
      bcnt++;
      tick();
    end
    check("t4_restart_tail", bcnt, 8);
    check("t4_restart_pass", pass, 1'b1);

    // start ignored mid-DRAIN, then asynchronous reset
    dut_valid = 1'b1; dut_dout = 8'hA5;
    seed = 16'h0001; num_patterns = 16'd2; drain_len = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("t5_drain_sig", signature, 16'h01EF);
    check("t5_drain_key", key_out, 8'h04);
    seed = 16'h00FF; num_patterns = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_ign_busy", busy, 1'b1);
    check("t5_ign_dut_rst", dut_rst, 1'b0);
    check("t5_ign_key", key_out, 8'h04);
    check("t5_ign_sig", signature, 16'h037B);
    #2 HRESETn = 1'b0;
    #1;
    check("t5_arst_busy", busy, 1'b0);
    check("t5_arst_sig", signature, 16'h0000);
    check("t5_arst_key", key_out, 8'h01);
    check("t5_arst_data", data_out, 8'h00);
    check("t5_arst_done", done, 1'b0);
    check("t5_arst_dut_rst", dut_rst, 1'b0);
    #1 HRESETn = 1'b1;
    tick();
    check("t5_post_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
